// File: rtl/ysyx_23060124_data_sram.sv
// ysyx_23060124_data_sram
//   Word-addressed 32-bit data SRAM behind an AXI-lite style slave port with a
//   fixed, parameterisable access latency. Read and write channels run as two
//   independent FSMs, so one read and one write may be in flight at once.
//
// Parameters
//   BASE   byte address of word 0
//   DEPTH  number of 32-bit words (power of two)
//   LAT    accept-to-response latency in cycles (1..15)
//
// Ports
//   i_clk, i_rst_n                     clock (rising edge), async active-low reset
//   araddr/arvalid/arready             read address channel
//   rdata/rresp/rvalid/rready          read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready             write address channel
//   wdata/wstrb/wvalid/wready          write data channel, wstrb[i] enables byte i
//   bresp/bvalid/bready                write response channel
//
// All outputs are decoded from or copied out of registers; there is no
// combinational path from an input to an output.

module ysyx_23060124_data_sram #(
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SpanBytes = 32'(4 * DEPTH);
    localparam logic [3:0]  CntInit   = 4'(LAT - 1);
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlv   = 2'b10;

    typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

    // Storage is deliberately not reset; contents survive i_rst_n.
    logic [31:0] mem [DEPTH];

    // Offset form avoids overflow of BASE + 4*DEPTH near the top of the map.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (addr >= BASE) && (off < SpanBytes);
    endfunction

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [31:0] r_addr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs;
    logic        r_fire;
    logic [IdxW-1:0] r_idx;

    assign ar_hs  = arvalid && (r_state_q == RIdle);
    // Storage is sampled on the edge that enters RResp.
    assign r_fire = (r_state_q == RWait) && (r_cnt_q == 4'd0);
    assign r_idx  = r_addr_q[IdxW+1:2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= RIdle;
            r_cnt_q   <= 4'd0;
            r_addr_q  <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RespOkay;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            if (ar_hs) begin
                r_addr_q <= araddr;
            end
            if (r_fire) begin
                if (in_range(r_addr_q)) begin
                    rdata_q <= mem[r_idx];
                    rresp_q <= RespOkay;
                end else begin
                    rdata_q <= 32'd0;
                    rresp_q <= RespSlv;
                end
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            RIdle: begin
                if (arvalid) begin
                    r_state_d = RWait;
                    r_cnt_d   = CntInit;
                end
            end
            RWait: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = RResp;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            RResp: begin
                if (rready) begin
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] aw_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_hs, w_hs;
    logic        have_aw, have_w;
    logic        commit;
    logic        mem_we;
    logic [31:0] cm_addr, cm_data;
    logic [3:0]  cm_strb;
    logic [IdxW-1:0] cm_idx;

    assign aw_hs   = awvalid && (w_state_q == WIdle) && !aw_got_q;
    assign w_hs    = wvalid && (w_state_q == WIdle) && !w_got_q;
    assign have_aw = aw_got_q || aw_hs;
    assign have_w  = w_got_q || w_hs;
    assign commit  = (w_state_q == WIdle) && have_aw && have_w;

    // A half captured earlier comes from its register, the other straight off the bus.
    assign cm_addr = aw_got_q ? aw_addr_q : awaddr;
    assign cm_data = w_got_q ? wdata_q : wdata;
    assign cm_strb = w_got_q ? wstrb_q : wstrb;
    assign cm_idx  = cm_addr[IdxW+1:2];
    // No commit may slip into storage while reset is held.
    assign mem_we  = commit && in_range(cm_addr) && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= WIdle;
            w_cnt_q   <= 4'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_addr_q <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            bresp_q   <= bresp_d;
            if (aw_hs) begin
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) begin
                    mem[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            WIdle: begin
                if (commit) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = WWait;
                    w_cnt_d   = CntInit;
                    bresp_d   = in_range(cm_addr) ? RespOkay : RespSlv;
                end else begin
                    aw_got_d = have_aw;
                    w_got_d  = have_w;
                end
            end
            WWait: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d = WResp;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            WResp: begin
                if (bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        arready = (r_state_q == RIdle);
        rvalid  = (r_state_q == RResp);
        rdata   = rdata_q;
        rresp   = rresp_q;
        awready = (w_state_q == WIdle) && !aw_got_q;
        wready  = (w_state_q == WIdle) && !w_got_q;
        bvalid  = (w_state_q == WResp);
        bresp   = bresp_q;
    end

endmodule

// File: tb/tb_ysyx_23060124_data_sram.sv
// Directed testbench for ysyx_23060124_data_sram. Unit 0 uses LAT=2, unit 1 uses
// LAT=1; both share the clock. Inputs change and outputs are sampled 1 time unit
// after each rising edge.

module tb_ysyx_23060124_data_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] araddr [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rready [2];
    logic [31:0] awaddr [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp [2];
    logic        bvalid [2];
    logic        bready [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060124_data_sram #(.BASE(32'h8000_0000), .DEPTH(256), .LAT(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    ysyx_23060124_data_sram #(.BASE(32'h8000_0000), .DEPTH(256), .LAT(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write; lat = edges from completing handshake to bvalid (99 on timeout).
    task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp, output int lat);
        bit ad, wd, ah, wh;
        int n;
        ad = 0; wd = 0; n = 0;
        awaddr[u] = a; wdata[u] = d; wstrb[u] = s;
        awvalid[u] = 1'b1; wvalid[u] = 1'b1;
        while (!(ad && wd) && n < 20) begin
            ah = awvalid[u] && awready[u];
            wh = wvalid[u] && wready[u];
            tick(); n++;
            if (ah) begin ad = 1; awvalid[u] = 1'b0; end
            if (wh) begin wd = 1; wvalid[u] = 1'b0; end
        end
        awvalid[u] = 1'b0; wvalid[u] = 1'b0;
        lat = 0;
        while (!bvalid[u] && lat < 20) begin tick(); lat++; end
        if (!bvalid[u]) lat = 99;
        resp = bresp[u];
        bready[u] = 1'b1; tick(); bready[u] = 1'b0;
    endtask

    // Full read; lat = edges from AR handshake to rvalid (99 on timeout).
    task automatic rd(input int u, input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] resp, output int lat);
        int n;
        n = 0;
        araddr[u] = a; arvalid[u] = 1'b1;
        while (!arready[u] && n < 20) begin tick(); n++; end
        tick();
        arvalid[u] = 1'b0;
        lat = 0;
        while (!rvalid[u] && lat < 20) begin tick(); lat++; end
        if (!rvalid[u]) lat = 99;
        d = rdata[u]; resp = rresp[u];
        rready[u] = 1'b1; tick(); rready[u] = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (rvalid[0] !== 1'b0) begin n_fail++;
            $display("FAIL reset rvalid: got %b want 0", rvalid[0]); end
        n_chk++; if (bvalid[0] !== 1'b0) begin n_fail++;
            $display("FAIL reset bvalid: got %b want 0", bvalid[0]); end
        n_chk++; if (rdata[0] !== 32'd0) begin n_fail++;
            $display("FAIL reset rdata: got %h want 0", rdata[0]); end
        n_chk++; if (rresp[0] !== 2'b00 || bresp[0] !== 2'b00) begin n_fail++;
            $display("FAIL reset resp: got %b/%b want 00/00", rresp[0], bresp[0]); end
        n_chk++; if (arready[0] !== 1'b1 || awready[0] !== 1'b1 || wready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready: got %b%b%b want 111", arready[0], awready[0], wready[0]);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
        n_chk++; if (lat !== 2) begin n_fail++;
            $display("FAIL basic write latency: got %0d want 2", lat); end
        n_chk++; if (r !== 2'b00) begin n_fail++;
            $display("FAIL basic bresp: got %b want 00", r); end
        rd(0, 32'h8000_0010, d, r, lat);
        n_chk++; if (lat !== 2) begin n_fail++;
            $display("FAIL basic read latency: got %0d want 2", lat); end
        n_chk++; if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin n_fail++;
            $display("FAIL basic readback: got %h/%b want deadbeef/00", d, r); end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(0, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, r, lat);
        // W first, AW three cycles later
        wdata[0] = 32'h1122_3344; wstrb[0] = 4'b0101; wvalid[0] = 1'b1;
        tick();
        wvalid[0] = 1'b0;
        n_chk++; if (wready[0] !== 1'b0 || awready[0] !== 1'b1 || bvalid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe w-capture: got wr=%b awr=%b bv=%b want 0 1 0",
                     wready[0], awready[0], bvalid[0]);
        end
        tick(); tick();
        awaddr[0] = 32'h8000_0020; awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        lat = 0;
        while (!bvalid[0] && lat < 20) begin tick(); lat++; end
        n_chk++; if (lat !== 2 || bresp[0] !== 2'b00) begin n_fail++;
            $display("FAIL strobe write: got lat=%0d bresp=%b want 2/00", lat, bresp[0]); end
        bready[0] = 1'b1; tick(); bready[0] = 1'b0;
        rd(0, 32'h8000_0020, d, r, lat);
        n_chk++; if (d !== 32'hFF22_FF44) begin n_fail++;
            $display("FAIL strobe readback: got %h want ff22ff44", d); end
        wr(0, 32'h8000_0020, 32'h0000_0000, 4'b0000, r, lat);
        n_chk++; if (r !== 2'b00) begin n_fail++;
            $display("FAIL strobe zero bresp: got %b want 00", r); end
        rd(0, 32'h8000_0020, d, r, lat);
        n_chk++; if (d !== 32'hFF22_FF44) begin n_fail++;
            $display("FAIL strobe zero readback: got %h want ff22ff44", d); end
    endtask

    task automatic test_oob();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(0, 32'h8000_03FC, 32'h600D_F00D, 4'hF, r, lat);
        n_chk++; if (r !== 2'b00) begin n_fail++;
            $display("FAIL oob last-word bresp: got %b want 00", r); end
        rd(0, 32'h8000_0400, d, r, lat);
        n_chk++; if (r !== 2'b10 || d !== 32'd0 || lat !== 2) begin n_fail++;
            $display("FAIL oob read: got %b/%h/lat %0d want 10/0/2", r, d, lat); end
        wr(0, 32'h7FFF_FFFC, 32'h0BAD_BAD0, 4'hF, r, lat);
        n_chk++; if (r !== 2'b10 || lat !== 2) begin n_fail++;
            $display("FAIL oob write: got %b/lat %0d want 10/2", r, lat); end
        rd(0, 32'h8000_03FC, d, r, lat);
        n_chk++; if (d !== 32'h600D_F00D) begin n_fail++;
            $display("FAIL oob alias word: got %h want 600df00d", d); end
        rd(0, 32'h8000_0010, d, r, lat);
        n_chk++; if (d !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL oob other word: got %h want deadbeef", d); end
    endtask

    task automatic test_backpressure();
        araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF || arready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure hold %0d: got rv=%b d=%h ar=%b want 1 deadbeef 0",
                         i, rvalid[0], rdata[0], arready[0]);
            end
            tick();
        end
        rready[0] = 1'b1; tick(); rready[0] = 1'b0;
        n_chk++; if (rvalid[0] !== 1'b0 || arready[0] !== 1'b1) begin n_fail++;
            $display("FAIL backpressure release: got rv=%b ar=%b want 0 1",
                     rvalid[0], arready[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int lat;
        araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1;
        awaddr[0] = 32'h8000_0010; awvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0; awvalid[0] = 1'b0;
        n_chk++; if (arready[0] !== 1'b0 || awready[0] !== 1'b0 || wready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset setup: got ar=%b aw=%b w=%b want 0 0 1",
                     arready[0], awready[0], wready[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (rvalid[0] !== 1'b0 || bvalid[0] !== 1'b0 || arready[0] !== 1'b1 ||
                     awready[0] !== 1'b1 || wready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset immediate: got rv=%b bv=%b ar=%b aw=%b w=%b want 0 0 1 1 1",
                     rvalid[0], bvalid[0], arready[0], awready[0], wready[0]);
        end
        #3 rst_n = 1'b1;
        tick(); tick(); tick();
        n_chk++; if (rvalid[0] !== 1'b0) begin n_fail++;
            $display("FAIL midreset abandoned read: got rv=%b want 0", rvalid[0]); end
        // Lone W must not pair with the pre-reset AW
        wdata[0] = 32'hBAD0_BAD0; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
        tick();
        wvalid[0] = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (bvalid[0] !== 1'b0) begin n_fail++;
            $display("FAIL midreset stale aw: got bv=%b want 0", bvalid[0]); end
        awaddr[0] = 32'h8000_0044; awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        lat = 0;
        while (!bvalid[0] && lat < 20) begin tick(); lat++; end
        bready[0] = 1'b1; tick(); bready[0] = 1'b0;
        rd(0, 32'h8000_0010, d, r, lat);
        n_chk++; if (d !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL midreset storage: got %h want deadbeef", d); end
        rd(0, 32'h8000_0044, d, r, lat);
        n_chk++; if (d !== 32'hBAD0_BAD0) begin n_fail++;
            $display("FAIL midreset later write: got %h want bad0bad0", d); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(1, 32'h8000_0008, 32'h1234_5678, 4'hF, r, lat);
        n_chk++; if (lat !== 1 || r !== 2'b00) begin n_fail++;
            $display("FAIL lat1 write: got lat %0d resp %b want 1/00", lat, r); end
        araddr[1] = 32'h8000_0008; arvalid[1] = 1'b1;
        awaddr[1] = 32'h8000_000C; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        n_chk++; if (rvalid[1] !== 1'b0 || bvalid[1] !== 1'b0) begin n_fail++;
            $display("FAIL concurrent early: got rv=%b bv=%b want 0 0", rvalid[1], bvalid[1]); end
        tick();
        n_chk++; if (rvalid[1] !== 1'b1 || bvalid[1] !== 1'b1 || rdata[1] !== 32'h1234_5678 ||
                     rresp[1] !== 2'b00 || bresp[1] !== 2'b00) begin
            n_fail++;
            $display("FAIL concurrent resp: got rv=%b bv=%b d=%h rr=%b br=%b want 1 1 12345678 00 00",
                     rvalid[1], bvalid[1], rdata[1], rresp[1], bresp[1]);
        end
        rready[1] = 1'b1; tick(); rready[1] = 1'b0;
        n_chk++; if (rvalid[1] !== 1'b0 || bvalid[1] !== 1'b1) begin n_fail++;
            $display("FAIL concurrent independent: got rv=%b bv=%b want 0 1",
                     rvalid[1], bvalid[1]);
        end
        bready[1] = 1'b1; tick(); bready[1] = 1'b0;
        rd(1, 32'h8000_000C, d, r, lat);
        n_chk++; if (d !== 32'hCAFE_F00D || lat !== 1) begin n_fail++;
            $display("FAIL concurrent readback: got %h lat %0d want cafef00d 1", d, lat); end
        // Read samples storage on the same edge the write commits: old data expected
        araddr[1] = 32'h8000_0008; arvalid[1] = 1'b1;
        tick();
        arvalid[1] = 1'b0;
        awaddr[1] = 32'h8000_0008; wdata[1] = 32'h8765_4321; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        n_chk++; if (rvalid[1] !== 1'b1 || rdata[1] !== 32'h1234_5678 || bvalid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL same-edge hazard: got rv=%b d=%h bv=%b want 1 12345678 0",
                     rvalid[1], rdata[1], bvalid[1]);
        end
        rready[1] = 1'b1; tick(); rready[1] = 1'b0;
        bready[1] = 1'b1; tick(); bready[1] = 1'b0;
        rd(1, 32'h8000_0008, d, r, lat);
        n_chk++; if (d !== 32'h8765_4321) begin n_fail++;
            $display("FAIL same-edge later read: got %h want 87654321", d); end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            araddr[u] = '0; arvalid[u] = 1'b0; rready[u] = 1'b0;
            awaddr[u] = '0; awvalid[u] = 1'b0; wdata[u] = '0; wstrb[u] = '0;
            wvalid[u] = 1'b0; bready[u] = 1'b0;
        end
        rst_n = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_strobe();
        test_oob();
        test_backpressure();
        test_reset_mid();
        test_concurrent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
